// File: rtl/down_counter_timer.sv
// Loadable down counter/timer: load a start value, decrement on enable, stop at zero, one-cycle done pulse.
// Latency 1 cycle from load; define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN for periodic reload after done.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, done_q;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = load_value;
      state_d = (load_value != '0) ? RUN : IDLE;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_d = load_value;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (enable && count_q != '0) begin
            count_d = count_q - 1'b1;
            if (count_q == WIDTH'(1)) state_d = DONE;
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            state_d = RUN;
            count_d = reload_q;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
`else
          state_d = IDLE;
          count_d = '0;
`endif
        end
        default: begin
          // IDLE ignores enable so a zero count can never wrap
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with a cycle-level behavioural model and literal spot checks.
module tb_down_counter_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, load, enable;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         busy, done;

  int vectors = 0;
  int errors  = 0;

  // Model: remaining count, whether a countdown is in progress, whether a done cycle is showing
  int m_count  = 0;
  bit m_run    = 0;
  bit m_done   = 0;
  int m_reload = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_count = 0; m_run = 0; m_done = 0; m_reload = 0;
    end else if (load) begin
      m_reload = int'(load_value);
      m_count  = int'(load_value);
      m_run    = (load_value != 0);
      m_done   = 0;
    end else if (m_run) begin
      if (enable) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end else if (m_done) begin
      m_done = 0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      if (m_reload != 0) begin
        m_count = m_reload;
        m_run   = 1;
      end
`endif
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("count", int'(count), m_count);
    chk("busy",  int'(busy),  int'(m_run));
    chk("done",  int'(done),  int'(m_done));
  endtask

  task automatic drive(input bit r, input bit l, input int v, input bit e);
    reset = r; load = l; load_value = W'(v); enable = e;
  endtask

  initial begin
    drive(1, 0, 0, 0);

    // T1: reset, then enable with no load never wraps
    cyc(); cyc();
    chk("t1_reset_count", int'(count), 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc();
    chk("t1_no_wrap", int'(count), 0);
    chk("t1_busy", int'(busy), 0);

    // T2: load 5, count to 0
    drive(0, 1, 5, 1);
    cyc();
    chk("t2_load", int'(count), 5);
    chk("t2_busy", int'(busy), 1);
    drive(0, 0, 0, 1);
    for (int i = 4; i >= 0; i--) begin
      cyc();
      chk("t2_seq", int'(count), i);
    end
    chk("t2_done", int'(done), 1);
    chk("t2_busy_at_done", int'(busy), 0);
    cyc();
    chk("t2_done_clear", int'(done), 0);
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    chk("t2_idle_count", int'(count), 0);
`endif
    drive(0, 1, 0, 1);
    cyc();

    // T3: hold with enable low
    drive(0, 1, 6, 1);
    cyc();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc();
    chk("t3_at3", int'(count), 3);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc();
    chk("t3_hold", int'(count), 3);
    chk("t3_hold_busy", int'(busy), 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc();
    chk("t3_zero", int'(count), 0);
    chk("t3_done", int'(done), 1);
    drive(0, 1, 0, 1);
    cyc();

    // T4: reload mid-run, aborted run gives no done
    drive(0, 1, 4, 1);
    cyc();
    drive(0, 0, 0, 1);
    cyc(); cyc();
    chk("t4_at2", int'(count), 2);
    drive(0, 1, 9, 1);
    cyc();
    chk("t4_reload", int'(count), 9);
    chk("t4_no_done", int'(done), 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc();
    chk("t4_done", int'(done), 1);
    drive(0, 1, 0, 1);
    cyc();

    // T5: reset mid-run, then load of zero
    drive(0, 1, 7, 1);
    cyc();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_at4", int'(count), 4);
    drive(1, 0, 0, 1);
    cyc();
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc();
    drive(0, 1, 0, 1);
    cyc();
    chk("t5_zero_done", int'(done), 0);
    chk("t5_zero_busy", int'(busy), 0);
    drive(0, 0, 0, 1);
    cyc();

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // T6: periodic reload, then cancel with load 0 during done
    begin
      int exp_seq [12] = '{3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0};
      drive(0, 1, 3, 1);
      cyc();
      chk("t6_seq", int'(count), exp_seq[0]);
      drive(0, 0, 0, 1);
      for (int i = 1; i < 12; i++) begin
        cyc();
        chk("t6_seq", int'(count), exp_seq[i]);
        chk("t6_done", int'(done), (exp_seq[i] == 0) ? 1 : 0);
      end
      drive(0, 1, 0, 1);
      cyc();
      chk("t6_cancel_busy", int'(busy), 0);
      chk("t6_cancel_count", int'(count), 0);
      drive(0, 0, 0, 1);
      cyc(); cyc();
      chk("t6_idle_done", int'(done), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
